// File: rtl/traffic_phase_timer_if.sv
// Bundle between the light controller and the phase timer.
//   main_green, side_green, warning : phase indication from the controller
//   ped_button                      : raw asynchronous pedestrian push-button
//   timer_done                      : one-cycle phase-expiry pulse to the controller
//   pedestrian_request              : latched pedestrian request level
//   fault                           : illegal phase indication seen last cycle
// master = light controller side, slave = timer side.
interface traffic_phase_timer_if;
  logic main_green;
  logic side_green;
  logic warning;
  logic ped_button;
  logic timer_done;
  logic pedestrian_request;
  logic fault;

  modport master (
    output main_green, side_green, warning, ped_button,
    input  timer_done, pedestrian_request, fault
  );

  modport slave (
    input  main_green, side_green, warning, ped_button,
    output timer_done, pedestrian_request, fault
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase timer for a main/side traffic light controller.
// Watches the one-hot phase code {main_green, side_green, warning}, times each phase with a
// prescaled 8-bit down-counter and pulses timer_done once on expiry. A synchronized pedestrian
// button latches a request that may restart the side-green phase once with PED_TICKS.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : traffic_phase_timer_if.slave (phase inputs, button, timer_done/request/fault outputs)
module traffic_phase_timer #(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned MAIN_TICKS   = 30,
  parameter int unsigned SIDE_TICKS   = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned PED_TICKS    = 15
) (
  input logic                  clk,
  input logic                  rst,
  traffic_phase_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFire, StHold} state_e;

  localparam logic [15:0] PreMax = 16'(PRESCALE - 1);
  localparam logic [7:0]  MainN  = 8'(MAIN_TICKS);
  localparam logic [7:0]  SideN  = 8'(SIDE_TICKS);
  localparam logic [7:0]  YellN  = 8'(YELLOW_TICKS);
  localparam logic [7:0]  PedN   = 8'(PED_TICKS);

  state_e      state_q;
  logic [2:0]  prev_code_q;
  logic [7:0]  cnt_q;
  logic [15:0] pre_q;
  logic        sync1_q, sync2_q, sync3_q;
  logic        ped_req_q, served_q, timer_done_q, fault_q;

  logic [2:0]  code;
  logic        legal, entry, rise, serve, load, tick, last;
  logic [7:0]  load_val, eff_cnt;
  logic [15:0] eff_pre;

  always_comb begin
    code     = {bus.main_green, bus.side_green, bus.warning};
    legal    = $onehot(code);
    entry    = legal && (code != prev_code_q);
    rise     = sync2_q & ~sync3_q;
    // A restart is allowed on the side-green entry cycle itself (served flag is stale there)
    // or while still counting a side phase that has not been restarted yet.
    serve    = legal && bus.side_green && ped_req_q && !timer_done_q &&
               (entry || (state_q == StRun && !served_q));
    load     = entry || serve;
    load_val = serve ? PedN : (bus.main_green ? MainN : (bus.side_green ? SideN : YellN));
    // The load cycle is itself the first prescaler cycle: counting starts from a cleared
    // prescaler and the full duration in that same cycle, so the pulse lands on N*PRESCALE.
    eff_cnt  = load ? load_val : cnt_q;
    eff_pre  = load ? 16'd0 : pre_q;
    tick     = (eff_pre == PreMax);
    last     = tick && (eff_cnt == 8'd1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      prev_code_q  <= 3'b000;
      cnt_q        <= 8'd0;
      pre_q        <= 16'd0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      ped_req_q    <= 1'b0;
      served_q     <= 1'b0;
      timer_done_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      prev_code_q  <= code;
      sync1_q      <= bus.ped_button;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      fault_q      <= !legal;
      timer_done_q <= 1'b0;

      if (serve) begin
        ped_req_q <= 1'b0;
      end else if (rise) begin
        ped_req_q <= 1'b1;
      end

      if (serve) begin
        served_q <= 1'b1;
      end else if (entry) begin
        served_q <= 1'b0;
      end

      if (!legal) begin
        state_q <= StIdle;
        cnt_q   <= 8'd0;
        pre_q   <= 16'd0;
      end else if (load || state_q == StRun) begin
        if (tick) begin
          pre_q <= 16'd0;
          if (last) begin
            cnt_q        <= 8'd0;
            state_q      <= StFire;
            timer_done_q <= 1'b1;
          end else begin
            cnt_q   <= eff_cnt - 8'd1;
            state_q <= StRun;
          end
        end else begin
          pre_q   <= eff_pre + 16'd1;
          cnt_q   <= eff_cnt;
          state_q <= StRun;
        end
      end else if (state_q == StFire) begin
        state_q <= StHold;
      end
    end
  end

  assign bus.timer_done         = timer_done_q;
  assign bus.pedestrian_request = ped_req_q;
  assign bus.fault              = fault_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
module tb_traffic_phase_timer;

  logic       clk;
  logic       rst;
  logic [2:0] code_a, code_b;
  logic       ped_a, ped_b;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         q_a[$];
  int         q_b[$];

  traffic_phase_timer_if bus_a ();
  traffic_phase_timer_if bus_b ();

  assign bus_a.main_green = code_a[2];
  assign bus_a.side_green = code_a[1];
  assign bus_a.warning    = code_a[0];
  assign bus_a.ped_button = ped_a;
  assign bus_b.main_green = code_b[2];
  assign bus_b.side_green = code_b[1];
  assign bus_b.warning    = code_b[0];
  assign bus_b.ped_button = ped_b;

  // A: PRESCALE=1, MAIN=3, SIDE=10, YELLOW=4, PED=5
  traffic_phase_timer #(
    .PRESCALE(1), .MAIN_TICKS(3), .SIDE_TICKS(10), .YELLOW_TICKS(4), .PED_TICKS(5)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  // B: PRESCALE=2, MAIN=3, SIDE=6, YELLOW=2, PED=3
  traffic_phase_timer #(
    .PRESCALE(2), .MAIN_TICKS(3), .SIDE_TICKS(6), .YELLOW_TICKS(2), .PED_TICKS(3)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitors: each timer_done pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (q_a.size() > 0 && q_a[0] < cyc) begin
      chk("a_missed_pulse", cyc, q_a[0]);
      void'(q_a.pop_front());
    end
    if (bus_a.timer_done === 1'b1) begin
      if (q_a.size() == 0) chk("a_spurious_pulse", cyc, -1);
      else chk("a_pulse_cycle", cyc, q_a.pop_front());
    end
  end

  always @(negedge clk) begin
    if (q_b.size() > 0 && q_b[0] < cyc) begin
      chk("b_missed_pulse", cyc, q_b[0]);
      void'(q_b.pop_front());
    end
    if (bus_b.timer_done === 1'b1) begin
      if (q_b.size() == 0) chk("b_spurious_pulse", cyc, -1);
      else chk("b_pulse_cycle", cyc, q_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst    = 1'b0;
    code_a = 3'b000;
    code_b = 3'b000;
    ped_a  = 1'b0;
    ped_b  = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_done_a",  int'(bus_a.timer_done), 0);
    chk("rst_req_a",   int'(bus_a.pedestrian_request), 0);
    chk("rst_fault_a", int'(bus_a.fault), 0);
    chk("rst_done_b",  int'(bus_b.timer_done), 0);
    chk("rst_req_b",   int'(bus_b.pedestrian_request), 0);
    chk("rst_fault_b", int'(bus_b.fault), 0);

    // First cycle after reset: A enters main, B enters warning.
    @(posedge clk);
    #1;
    rst    = 1'b1;
    code_a = 3'b100;
    code_b = 3'b001;
    q_a.push_back(cyc + 3);
    q_b.push_back(cyc + 4);

    fork
      begin : seq_a
        int b, w, s, m, s2, m2, s3;
        step(8);
        // Illegal 110 mid-count of a side phase, then main restarts a fresh count.
        t = cyc;
        code_a = 3'b010;
        step(2);
        code_a = 3'b110;
        @(negedge clk); chk("fault_lag", int'(bus_a.fault), 0);
        step(1); @(negedge clk); chk("fault_1", int'(bus_a.fault), 1);
        step(1); @(negedge clk); chk("fault_2", int'(bus_a.fault), 1);
        step(1);
        code_a = 3'b100;
        q_a.push_back(t + 8);
        @(negedge clk); chk("fault_3", int'(bus_a.fault), 1);
        step(1); @(negedge clk); chk("fault_clear", int'(bus_a.fault), 0);
        step(4);

        // Press during main HOLD, synchronizer latency.
        b = cyc;
        ped_a = 1'b1;
        @(negedge clk); chk("sync_b0", int'(bus_a.pedestrian_request), 0);
        step(1); @(negedge clk); chk("sync_b1", int'(bus_a.pedestrian_request), 0);
        step(1);
        ped_a = 1'b0;
        @(negedge clk); chk("sync_b2", int'(bus_a.pedestrian_request), 0);
        step(1); @(negedge clk); chk("sync_b3", int'(bus_a.pedestrian_request), 1);

        // Warning phase leaves the request latched.
        step(1);
        w = cyc;
        code_a = 3'b001;
        q_a.push_back(w + 4);
        step(6);
        @(negedge clk); chk("req_through_warn", int'(bus_a.pedestrian_request), 1);

        // Side entry with request: serve at entry, pulse at s+PED_TICKS.
        step(1);
        s = cyc;
        code_a = 3'b010;
        q_a.push_back(s + 5);
        @(negedge clk); chk("req_at_entry", int'(bus_a.pedestrian_request), 1);
        step(1);
        ped_a = 1'b1;
        @(negedge clk); chk("req_served", int'(bus_a.pedestrian_request), 0);
        step(1);
        ped_a = 1'b0;
        step(2); @(negedge clk); chk("req_relatch", int'(bus_a.pedestrian_request), 1);
        step(4); @(negedge clk); chk("req_hold_side", int'(bus_a.pedestrian_request), 1);

        // Next main then next side: request still pending and served there.
        step(1);
        m = cyc;
        code_a = 3'b100;
        q_a.push_back(m + 3);
        step(1); @(negedge clk); chk("req_in_main", int'(bus_a.pedestrian_request), 1);
        step(4);
        s2 = cyc;
        code_a = 3'b010;
        q_a.push_back(s2 + 5);
        @(negedge clk); chk("req_next_side", int'(bus_a.pedestrian_request), 1);
        step(1); @(negedge clk); chk("req_served2", int'(bus_a.pedestrian_request), 0);
        step(6);

        // Request arriving exactly in the side timer_done cycle: no restart, kept latched.
        m2 = cyc;
        code_a = 3'b100;
        q_a.push_back(m2 + 3);
        step(4);
        s3 = cyc;
        code_a = 3'b010;
        q_a.push_back(s3 + 10);
        step(7);
        ped_a = 1'b1;
        @(negedge clk); chk("req_pre_done", int'(bus_a.pedestrian_request), 0);
        step(1);
        ped_a = 1'b0;
        step(2); @(negedge clk); chk("req_at_done", int'(bus_a.pedestrian_request), 1);
        step(2); @(negedge clk); chk("req_kept", int'(bus_a.pedestrian_request), 1);
        step(5);
      end
      begin : seq_b
        int sb;
        // Warning pulse at cycle 4 of the phase, then silence through cycle 20.
        step(21);
        // Side entry, request arrives mid-count: serve at sb+3, pulse at sb+3+3*2.
        sb = cyc;
        code_b = 3'b010;
        q_b.push_back(sb + 9);
        ped_b = 1'b1;
        step(1);
        ped_b = 1'b0;
        step(2); @(negedge clk); chk("b_req_set", int'(bus_b.pedestrian_request), 1);
        step(1); @(negedge clk); chk("b_req_served", int'(bus_b.pedestrian_request), 0);
        step(10);
        code_b = 3'b000;
      end
    join

    // Reset asserted in the timer_done cycle.
    t = cyc;
    code_a = 3'b100;
    q_a.push_back(t + 3);
    step(3);
    rst = 1'b0;
    step(1);
    @(negedge clk);
    chk("rst_mid_done",  int'(bus_a.timer_done), 0);
    chk("rst_mid_req",   int'(bus_a.pedestrian_request), 0);
    chk("rst_mid_fault", int'(bus_a.fault), 0);
    step(1);
    rst = 1'b1;
    q_a.push_back(t + 8);
    step(10);

    foreach (q_a[i]) chk("a_pending_pulse", -1, q_a[i]);
    foreach (q_b[i]) chk("b_pending_pulse", -1, q_b[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
